// File: rtl/sign_extend_pkg.sv
// Shared widths, LEGv8 opcode constants and immediate-format enum for the
// sign-extension unit.
package sign_extend_pkg;

  localparam int unsigned INST_SIZE = 32;
  localparam int unsigned WORD      = 64;

  // Immediate field widths per format
  localparam int unsigned B_IMM_W  = 26;
  localparam int unsigned CB_IMM_W = 19;
  localparam int unsigned D_IMM_W  = 9;
  localparam int unsigned I_IMM_W  = 12;

  // B-format, inst[31:26]
  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

  // CB-format, inst[31:24]
  localparam logic [7:0] OP_CBZ   = 8'hB4;
  localparam logic [7:0] OP_CBNZ  = 8'hB5;
  localparam logic [7:0] OP_BCOND = 8'h54;

  // D-format, inst[31:21]
  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_STUR   = 11'h7C0;
  localparam logic [10:0] OP_LDURB  = 11'h1C2;
  localparam logic [10:0] OP_STURB  = 11'h1C0;
  localparam logic [10:0] OP_LDURH  = 11'h3C2;
  localparam logic [10:0] OP_STURH  = 11'h3C0;
  localparam logic [10:0] OP_LDURSW = 11'h5C4;
  localparam logic [10:0] OP_STURW  = 11'h5C0;
  localparam logic [10:0] OP_LDXR   = 11'h642;
  localparam logic [10:0] OP_STXR   = 11'h640;

  // I-format, inst[31:22]
  localparam logic [9:0] OP_ADDI  = 10'h244;
  localparam logic [9:0] OP_ADDIS = 10'h2C4;
  localparam logic [9:0] OP_SUBI  = 10'h344;
  localparam logic [9:0] OP_SUBIS = 10'h3C4;
  localparam logic [9:0] OP_ANDI  = 10'h248;
  localparam logic [9:0] OP_ANDIS = 10'h3C8;
  localparam logic [9:0] OP_ORRI  = 10'h2C8;
  localparam logic [9:0] OP_EORI  = 10'h348;

  typedef enum logic [2:0] {
    FMT_B,
    FMT_CB,
    FMT_D,
    FMT_I,
    FMT_DEFAULT
  } fmt_e;

endpackage

// File: rtl/sign_extend_imm_decode.sv
// Combinational LEGv8 immediate decoder: classifies the instruction format
// and produces the extended (unregistered) immediate.
module imm_decode #(
  parameter int unsigned INST_SIZE = sign_extend_pkg::INST_SIZE,
  parameter int unsigned WORD      = sign_extend_pkg::WORD
) (
  input  logic [INST_SIZE-1:0]  inst_i,
  output sign_extend_pkg::fmt_e fmt_c,
  output logic [WORD-1:0]       imm_c
);
  import sign_extend_pkg::*;

  logic [5:0]  op_b;
  logic [7:0]  op_cb;
  logic [10:0] op_d;
  logic [9:0]  op_i;

  assign op_b  = inst_i[31:26];
  assign op_cb = inst_i[31:24];
  assign op_d  = inst_i[31:21];
  assign op_i  = inst_i[31:22];

  // Priority B > CB > D > I > default; signed fields replicate their MSB
  always_comb begin
    fmt_c = FMT_DEFAULT;
    imm_c = WORD'(inst_i);
    if (op_b inside {OP_B, OP_BL}) begin
      fmt_c = FMT_B;
      imm_c = {{(WORD-B_IMM_W){inst_i[25]}}, inst_i[25:0]};
    end else if (op_cb inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
      fmt_c = FMT_CB;
      imm_c = {{(WORD-CB_IMM_W){inst_i[23]}}, inst_i[23:5]};
    end else if (op_d inside {OP_LDUR, OP_STUR, OP_LDURB, OP_STURB, OP_LDURH,
                              OP_STURH, OP_LDURSW, OP_STURW, OP_LDXR, OP_STXR}) begin
      fmt_c = FMT_D;
      imm_c = {{(WORD-D_IMM_W){inst_i[20]}}, inst_i[20:12]};
    end else if (op_i inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                              OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
      fmt_c = FMT_I;
      imm_c = {{(WORD-I_IMM_W){1'b0}}, inst_i[21:10]};
    end
  end

endmodule

// File: rtl/sign_extend.sv
// LEGv8 immediate extender: decodes the instruction immediate and presents
// it one cycle later on ex_data.
module sign_extend #(
  parameter int unsigned INST_SIZE = sign_extend_pkg::INST_SIZE,
  parameter int unsigned WORD      = sign_extend_pkg::WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INST_SIZE-1:0] inst,
  output logic [WORD-1:0]      ex_data
);
  import sign_extend_pkg::*;

  fmt_e            fmt;
  logic [WORD-1:0] ex_data_d;
  logic [WORD-1:0] ex_data_q;

  imm_decode #(
    .INST_SIZE(INST_SIZE),
    .WORD     (WORD)
  ) u_imm_decode (
    .inst_i(inst),
    .fmt_c (fmt),
    .imm_c (ex_data_d)
  );

  // Decoder must always land on a defined format
  always_comb begin
    assert (fmt inside {FMT_B, FMT_CB, FMT_D, FMT_I, FMT_DEFAULT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_data_q <= '0;
    end else begin
      ex_data_q <= ex_data_d;
    end
  end

  assign ex_data = ex_data_q;

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: table of known encodings streamed
// back-to-back through a scoreboard, plus reset corner sequences.
module tb_sign_extend;

  localparam int unsigned INST_SIZE = 32;
  localparam int unsigned WORD      = 64;

  logic                 clk;
  logic                 rst_n;
  logic [INST_SIZE-1:0] inst;
  logic [WORD-1:0]      ex_data;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];
  string       sb_name[$];
  int          n_cmp;
  int          n_bad;
  logic [63:0] last_exp;

  sign_extend #(
    .INST_SIZE(INST_SIZE),
    .WORD     (WORD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inst   (inst),
    .ex_data(ex_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: ex_data=%h expected=%h", name, got, exp);
    end
  endtask

  // Drive one instruction and queue its expected result
  task automatic drive(input logic [31:0] v, input logic [63:0] e, input string name);
    inst = v;
    sb_q.push_back(e);
    sb_name.push_back(name);
  endtask

  // Advance one edge and retire the oldest scoreboard entry
  task automatic retire();
    logic [63:0] e;
    string       nm;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: ex_data=%h expected=<none>", ex_data);
    end else begin
      e  = sb_q.pop_front();
      nm = sb_name.pop_front();
      check(nm, ex_data, e);
      last_exp = e;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_exp = '0;

    vecs.push_back('{32'hF84402C9, 64'd64,                  "ldur_64"});
    vecs.push_back('{32'hF80602CB, 64'd96,                  "stur_96"});
    vecs.push_back('{32'hB4FFFF6B, 64'hFFFFFFFFFFFFFFFB,    "cbz_m5"});
    vecs.push_back('{32'hB4000109, 64'd8,                   "cbz_8"});
    vecs.push_back('{32'h14000040, 64'd64,                  "b_64"});
    vecs.push_back('{32'h17FFFFC9, 64'hFFFFFFFFFFFFFFC9,    "b_m55"});
    vecs.push_back('{32'h8B09026A, 64'h000000008B09026A,    "add_r"});
    vecs.push_back('{32'hCB0A028B, 64'h00000000CB0A028B,    "sub_r"});
    vecs.push_back('{32'hAA150149, 64'h00000000AA150149,    "orr_r"});
    vecs.push_back('{32'h8A0A02C9, 64'h000000008A0A02C9,    "and_r"});
    vecs.push_back('{32'h910FFC00, 64'h00000000000003FF,    "addi_3ff"});
    vecs.push_back('{32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFF,    "b_all_ones"});
    vecs.push_back('{32'h16000000, 64'hFFFFFFFFFE000000,    "b_most_neg"});
    vecs.push_back('{32'h94000001, 64'd1,                   "bl_1"});
    vecs.push_back('{32'hB4FFFFE0, 64'hFFFFFFFFFFFFFFFF,    "cbz_all_ones"});
    vecs.push_back('{32'h54800000, 64'hFFFFFFFFFFFC0000,    "bcond_most_neg"});
    vecs.push_back('{32'h54000040, 64'd2,                   "bcond_2"});
    vecs.push_back('{32'hF85FF000, 64'hFFFFFFFFFFFFFFFF,    "ldur_all_ones"});
    vecs.push_back('{32'hF8500000, 64'hFFFFFFFFFFFFFF00,    "ldur_most_neg"});
    vecs.push_back('{32'hB8840000, 64'd64,                  "ldursw_64"});
    vecs.push_back('{32'hC81FF000, 64'hFFFFFFFFFFFFFFFF,    "stxr_all_ones"});
    vecs.push_back('{32'h923FFC00, 64'h0000000000000FFF,    "andi_fff_zext"});
    vecs.push_back('{32'hB2200000, 64'h0000000000000800,    "orri_800_zext"});
    vecs.push_back('{32'hFFFFFFFF, 64'h00000000FFFFFFFF,    "unknown_zext"});

    // Asynchronous reset: output clears before any clock edge
    rst_n = 1'b0;
    inst  = 32'hF84402C9;
    #3;
    check("reset_async_no_edge", ex_data, 64'd0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", ex_data, 64'd0);

    // First edge after deassertion loads the current instruction
    #3;
    rst_n = 1'b1;
    drive(32'hF84402C9, 64'd64, "first_edge_after_reset");
    retire();

    // Table streamed back-to-back, one new instruction per cycle
    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].exp, vecs[i].name);
      retire();
    end

    // Changing inst mid-cycle must not reach ex_data before the edge
    inst = 32'h14000040;
    #3;
    check("no_comb_path", ex_data, last_exp);
    drive(32'h14000040, 64'd64, "after_comb_check");
    retire();

    // Mid-stream reset discards the pending value
    inst = 32'h17FFFFC9;
    #2;
    rst_n = 1'b0;
    #1;
    check("midstream_reset_clear", ex_data, 64'd0);
    @(posedge clk);
    #1;
    check("midstream_reset_hold", ex_data, 64'd0);
    #3;
    rst_n = 1'b1;
    drive(32'h910FFC00, 64'h3FF, "reload_after_midstream_reset");
    retire();

    // Alternating formats every cycle after recovery
    drive(32'hB4FFFF6B, 64'hFFFFFFFFFFFFFFFB, "b2b_cbz");
    retire();
    drive(32'h8B09026A, 64'h000000008B09026A, "b2b_add");
    retire();
    drive(32'hF80602CB, 64'd96, "b2b_stur");
    retire();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: entries=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
